// File: rtl/mod_seq_pkg.sv
// Shared types and the modular step function for the mod-N sequence lock checker.
package mod_seq_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } stateT;

    localparam int DEF_MODULUS = 20;
    localparam int DEF_STEP    = 6;
    localparam int NEXT_W      = 16;

    // Wide intermediate so x+step never wraps before the modulus fold.
    function automatic logic [NEXT_W-1:0] mod_next(input logic [NEXT_W-1:0] x,
                                                   input logic [NEXT_W-1:0] step,
                                                   input logic [NEXT_W-1:0] modulus);
        logic [NEXT_W-1:0] s;
        s = x + step;
        return (s >= modulus) ? (s - modulus) : s;
    endfunction

endpackage

// File: rtl/mod_step_add.sv
// Combinational next(x) = (x+STEP) mod MODULUS for the lock checker.
module mod_step_add
    import mod_seq_pkg::*;
#(
    parameter int DATA_W  = 5,
    parameter int MODULUS = DEF_MODULUS,
    parameter int STEP    = DEF_STEP
) (
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    assign y = DATA_W'(mod_next(NEXT_W'(x), NEXT_W'(STEP), NEXT_W'(MODULUS)));

endmodule

// File: rtl/mod_seq_lock_checker.sv
// Lock/flywheel checker for the mod-MODULUS step-STEP sample stream.
// Optional SEQ_ERR_CAPTURE_EN adds first-mismatch capture outputs (cap_valid/cap_obs/cap_exp).
module mod_seq_lock_checker
    import mod_seq_pkg::*;
#(
    parameter int DATA_W     = 5,
    parameter int MODULUS    = DEF_MODULUS,
    parameter int STEP       = DEF_STEP,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              err_clr,
    output logic              locked,
    output logic [DATA_W-1:0] exp_data,
    output logic              match,
    output logic              mismatch,
    output logic              range_err,
    output logic [ERR_W-1:0]  err_count
`ifdef SEQ_ERR_CAPTURE_EN
    ,
    output logic              cap_valid,
    output logic [DATA_W-1:0] cap_obs,
    output logic [DATA_W-1:0] cap_exp
`endif
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_V   = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] UNLOCK_V = MISS_W'(UNLOCK_CNT);

    stateT              state, stateNxt;
    logic [DATA_W-1:0]  expReg, expNxt;
    logic [RUN_W-1:0]   runCnt, runNxt;
    logic [MISS_W-1:0]  missCnt, missNxt;
    logic [ERR_W-1:0]   errNxt;
    logic               matchNxt, mismatchNxt, rangeNxt;
    logic               outOfRange;
    logic [DATA_W-1:0]  stepIn, stepOut;

    assign outOfRange = {1'b0, in_data} >= (DATA_W+1)'(MODULUS);
    // LOCKED flywheels from the expected value; other states seed from the sample.
    assign stepIn     = (state == LOCKED) ? expReg : in_data;

    mod_step_add #(.DATA_W(DATA_W), .MODULUS(MODULUS), .STEP(STEP)) uStep (
        .x (stepIn),
        .y (stepOut)
    );

    always_comb begin
        stateNxt    = state;
        expNxt      = expReg;
        runNxt      = runCnt;
        missNxt     = missCnt;
        matchNxt    = 1'b0;
        mismatchNxt = 1'b0;
        rangeNxt    = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (outOfRange) begin
                        rangeNxt = 1'b1;
                    end else begin
                        expNxt   = stepOut;
                        runNxt   = '0;
                        stateNxt = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (outOfRange) begin
                        rangeNxt = 1'b1;
                        stateNxt = HUNT;
                    end else if (in_data == expReg) begin
                        matchNxt = 1'b1;
                        expNxt   = stepOut;
                        runNxt   = runCnt + RUN_W'(1);
                        if (runCnt + RUN_W'(1) == LOCK_V) begin
                            stateNxt = LOCKED;
                            missNxt  = '0;
                        end
                    end else begin
                        expNxt = stepOut;
                        runNxt = '0;
                    end
                end
                LOCKED: begin
                    expNxt   = stepOut;
                    rangeNxt = outOfRange;
                    if (!outOfRange && in_data == expReg) begin
                        matchNxt = 1'b1;
                        missNxt  = '0;
                    end else begin
                        mismatchNxt = 1'b1;
                        missNxt     = missCnt + MISS_W'(1);
                        if (missCnt + MISS_W'(1) == UNLOCK_V) stateNxt = HUNT;
                    end
                end
                default: stateNxt = HUNT;
            endcase
        end

        // A clear coinciding with a new mismatch keeps that mismatch.
        if (mismatchNxt)
            errNxt = err_clr ? ERR_W'(1) : ((&err_count) ? err_count : err_count + ERR_W'(1));
        else
            errNxt = err_clr ? '0 : err_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            expReg    <= '0;
            runCnt    <= '0;
            missCnt   <= '0;
            err_count <= '0;
            match     <= 1'b0;
            mismatch  <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= stateNxt;
            expReg    <= expNxt;
            runCnt    <= runNxt;
            missCnt   <= missNxt;
            err_count <= errNxt;
            match     <= matchNxt;
            mismatch  <= mismatchNxt;
            range_err <= rangeNxt;
        end
    end

    assign locked   = (state == LOCKED);
    assign exp_data = expReg;

`ifdef SEQ_ERR_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_obs   <= '0;
            cap_exp   <= '0;
        end else if (mismatchNxt && (!cap_valid || err_clr)) begin
            cap_valid <= 1'b1;
            cap_obs   <= in_data;
            cap_exp   <= expReg;
        end else if (err_clr) begin
            cap_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mod_seq_lock_checker.sv
// Randomized + directed bench for mod_seq_lock_checker against a rule-level reference model.
module tb_mod_seq_lock_checker;

    localparam int DW = 5, MOD = 20, STP = 6, LCK = 4, ULK = 3, EW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          err_clr = 1'b0;

    logic          locked, match, mismatch, range_err;
    logic [DW-1:0] exp_data;
    logic [EW-1:0] err_count;
    logic          locked2, match2, mismatch2, range_err2;
    logic [DW-1:0] exp_data2;
    logic [1:0]    err_count2;
`ifdef SEQ_ERR_CAPTURE_EN
    logic          cap_valid, cap_valid2;
    logic [DW-1:0] cap_obs, cap_exp, cap_obs2, cap_exp2;
`endif

    mod_seq_lock_checker #(.DATA_W(DW), .MODULUS(MOD), .STEP(STP), .LOCK_CNT(LCK),
                           .UNLOCK_CNT(ULK), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
        .locked(locked), .exp_data(exp_data), .match(match), .mismatch(mismatch),
        .range_err(range_err), .err_count(err_count)
`ifdef SEQ_ERR_CAPTURE_EN
        , .cap_valid(cap_valid), .cap_obs(cap_obs), .cap_exp(cap_exp)
`endif
    );

    mod_seq_lock_checker #(.DATA_W(DW), .MODULUS(MOD), .STEP(STP), .LOCK_CNT(LCK),
                           .UNLOCK_CNT(8), .ERR_W(2)) dutSat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
        .locked(locked2), .exp_data(exp_data2), .match(match2), .mismatch(mismatch2),
        .range_err(range_err2), .err_count(err_count2)
`ifdef SEQ_ERR_CAPTURE_EN
        , .cap_valid(cap_valid2), .cap_obs(cap_obs2), .cap_exp(cap_exp2)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: 0=hunt 1=acquire 2=locked
    int mState, mExp, mRun, mMiss, mErr;
    bit mMatch, mMis, mRange;
    bit capV;
    int capO, capE;

    function automatic int nextVal(int x);
        return (x + STP) % MOD;
    endfunction

    function automatic void modelReset();
        mState = 0; mExp = 0; mRun = 0; mMiss = 0; mErr = 0;
        mMatch = 0; mMis = 0; mRange = 0;
        capV = 0; capO = 0; capE = 0;
    endfunction

    function automatic void modelStep(bit v, int d, bit clr);
        bit oor;
        bit bad;
        oor = (d >= MOD);
        bad = 0;
        mMatch = 0; mMis = 0; mRange = 0;
        if (v) begin
            if (mState == 0) begin
                if (oor) mRange = 1;
                else begin mExp = nextVal(d); mRun = 0; mState = 1; end
            end else if (mState == 1) begin
                if (oor) begin mRange = 1; mState = 0; end
                else if (d == mExp) begin
                    mMatch = 1; mRun++; mExp = nextVal(d);
                    if (mRun == LCK) begin mState = 2; mMiss = 0; end
                end else begin mExp = nextVal(d); mRun = 0; end
            end else begin
                mRange = oor;
                if (!oor && d == mExp) begin mMatch = 1; mMiss = 0; end
                else begin
                    bad = 1; mMis = 1; mMiss++;
                    if (capV == 0 || clr) begin capV = 1; capO = d; capE = mExp; end
                    if (mMiss == ULK) mState = 0;
                end
                mExp = nextVal(mExp);
            end
        end
        if (bad) mErr = clr ? 1 : ((mErr + 1 > (1 << EW) - 1) ? mErr : mErr + 1);
        else if (clr) mErr = 0;
        if (clr && !bad) capV = 0;
    endfunction

    task automatic step(input bit v, input int d, input bit clr);
        in_valid = v; in_data = DW'(d); err_clr = clr;
        @(posedge clk); #1;
        modelStep(v, d, clr);
        in_valid = 0; err_clr = 0;
    endtask

    task automatic doReset();
        rst = 1; in_valid = 0; err_clr = 0;
        @(posedge clk); #1;
        rst = 0;
        modelReset();
    endtask

    task automatic feedLock();
        step(1, 0, 0); step(1, 6, 0); step(1, 12, 0); step(1, 18, 0); step(1, 4, 0);
    endtask

    task automatic test_reset();
        doReset();
        nChecks++;
        if ({locked, exp_data, match, mismatch, range_err, err_count} !== '0) begin
            nFails++;
            $display("FAIL reset_outputs got locked=%0b exp=%0d m=%0b mm=%0b re=%0b err=%0d want all 0",
                     locked, exp_data, match, mismatch, range_err, err_count);
        end
    endtask

    task automatic test_lock();
        doReset();
        step(1, 0, 0); step(1, 6, 0); step(1, 12, 0); step(1, 18, 0);
        nChecks++;
        if (locked !== 1'b0) begin nFails++; $display("FAIL lock_early got %0b want 0", locked); end
        step(1, 4, 0);
        nChecks++;
        if ({locked, match, exp_data, err_count} !== {1'b1, 1'b1, 5'd10, 16'd0}) begin
            nFails++;
            $display("FAIL lock_entry got locked=%0b match=%0b exp=%0d err=%0d want 1 1 10 0",
                     locked, match, exp_data, err_count);
        end
    endtask

    task automatic test_unlock();
        int wantExp[3] = '{16, 2, 8};
        for (int i = 0; i < 3; i++) begin
            step(1, 7, 0);
            nChecks++;
            if ({mismatch, match, exp_data, err_count} !== {1'b1, 1'b0, DW'(wantExp[i]), EW'(i + 1)}) begin
                nFails++;
                $display("FAIL unlock_%0d got mm=%0b m=%0b exp=%0d err=%0d want 1 0 %0d %0d",
                         i, mismatch, match, exp_data, err_count, wantExp[i], i + 1);
            end
        end
        nChecks++;
        if (locked !== 1'b0) begin nFails++; $display("FAIL unlock_state got locked=%0b want 0", locked); end
`ifdef SEQ_ERR_CAPTURE_EN
        nChecks++;
        if ({cap_valid, cap_obs, cap_exp} !== {1'b1, 5'd7, 5'd10}) begin
            nFails++;
            $display("FAIL capture got v=%0b obs=%0d exp=%0d want 1 7 10", cap_valid, cap_obs, cap_exp);
        end
`endif
    endtask

    task automatic test_reseed();
        doReset();
        step(1, 3, 0);
        step(1, 5, 0);
        nChecks++;
        if ({match, exp_data, locked} !== {1'b0, 5'd11, 1'b0}) begin
            nFails++;
            $display("FAIL reseed got m=%0b exp=%0d locked=%0b want 0 11 0", match, exp_data, locked);
        end
        step(1, 11, 0); step(1, 17, 0); step(1, 3, 0); step(1, 9, 0);
        nChecks++;
        if (locked !== 1'b1) begin nFails++; $display("FAIL reseed_lock got %0b want 1", locked); end
    endtask

    task automatic test_range();
        doReset();
        step(1, 25, 0);
        nChecks++;
        if ({range_err, locked, match} !== 3'b100) begin
            nFails++;
            $display("FAIL range_hunt got re=%0b locked=%0b m=%0b want 1 0 0", range_err, locked, match);
        end
        feedLock();
        step(1, 31, 0);
        nChecks++;
        if ({range_err, mismatch, err_count, locked, exp_data} !== {1'b1, 1'b1, 16'd1, 1'b1, 5'd16}) begin
            nFails++;
            $display("FAIL range_locked got re=%0b mm=%0b err=%0d locked=%0b exp=%0d want 1 1 1 1 16",
                     range_err, mismatch, err_count, locked, exp_data);
        end
    endtask

    task automatic test_saturation();
        doReset();
        feedLock();
        for (int i = 0; i < 5; i++) step(1, 7, 0);
        nChecks++;
        if ({err_count2, locked2} !== {2'd3, 1'b1}) begin
            nFails++;
            $display("FAIL sat_count got err=%0d locked=%0b want 3 1", err_count2, locked2);
        end
        step(1, 7, 1);
        nChecks++;
        if ({err_count2, mismatch2} !== {2'd1, 1'b1}) begin
            nFails++;
            $display("FAIL sat_clr got err=%0d mm=%0b want 1 1", err_count2, mismatch2);
        end
        step(0, 0, 1);
        nChecks++;
        if (err_count2 !== 2'd0) begin nFails++; $display("FAIL clr_idle got %0d want 0", err_count2); end
    endtask

    task automatic test_reset_mid();
        doReset();
        feedLock();
        rst = 1; in_valid = 1; in_data = 5'd10; err_clr = 0;
        @(posedge clk); #1;
        rst = 0; in_valid = 0;
        modelReset();
        nChecks++;
        if ({locked, exp_data, match, mismatch, range_err, err_count} !== '0) begin
            nFails++;
            $display("FAIL reset_mid got locked=%0b exp=%0d m=%0b err=%0d want all 0",
                     locked, exp_data, match, err_count);
        end
    endtask

    task automatic test_random();
        int d, r;
        bit v, c;
        doReset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                r = $urandom_range(0, 9);
                if (r < 6)      d = mExp;
                else if (r < 9) d = $urandom_range(0, MOD - 1);
                else            d = $urandom_range(MOD, 31);
                v = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 29) == 0);
                step(v, d, c);
            end
            nChecks++;
            if ({locked, exp_data, match, mismatch, range_err, err_count} !==
                {(mState == 2), DW'(mExp), mMatch, mMis, mRange, EW'(mErr)}) begin
                nFails++;
                $display("FAIL random_%0d got locked=%0b exp=%0d m=%0b mm=%0b re=%0b err=%0d want %0b %0d %0b %0b %0b %0d",
                         n, locked, exp_data, match, mismatch, range_err, err_count,
                         (mState == 2), mExp, mMatch, mMis, mRange, mErr);
            end
`ifdef SEQ_ERR_CAPTURE_EN
            nChecks++;
            if (cap_valid !== capV || (capV && {cap_obs, cap_exp} !== {DW'(capO), DW'(capE)})) begin
                nFails++;
                $display("FAIL random_cap_%0d got v=%0b obs=%0d exp=%0d want %0b %0d %0d",
                         n, cap_valid, cap_obs, cap_exp, capV, capO, capE);
            end
`endif
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_lock();
        test_unlock();
        test_reseed();
        test_range();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
